// File: rtl/adbg_or1k_pkg.sv
// Shared constants and types for the or1k debug-module control shifter.
package adbg_or1k_pkg;

  localparam int unsigned HDR_W = 5;

  localparam logic [3:0] OpNop     = 4'h0;
  localparam logic [3:0] OpIregWr  = 4'h9;
  localparam logic [3:0] OpIregSel = 4'hD;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StWdata,
    StFull
  } state_e;

endpackage

// File: rtl/adbg_or1k_ctrl_shifter.sv
// JTAG DR shifter for the or1k stall-control register: decodes a short command frame,
// issues single-cycle writes and serialises the control word plus sticky error on readback.
module adbg_or1k_ctrl_shifter
  import adbg_or1k_pkg::*;
#(
  parameter int unsigned NB_CORES = 4
) (
  input  logic                tck_i,
  input  logic                tlr_i,
  input  logic                module_select_i,
  input  logic                capture_dr_i,
  input  logic                shift_dr_i,
  input  logic                update_dr_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  input  logic [NB_CORES-1:0] ctrl_reg_i,
  output logic                we_o,
  output logic [NB_CORES-1:0] data_o
);

  localparam int unsigned CntMax = HDR_W + NB_CORES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_nxt;
  logic [HDR_W-1:0]    hdr_q;
  logic [NB_CORES-1:0] wdat_q;
  logic [NB_CORES:0]   out_sr_q;
  logic                err_q;
  logic                rd_armed_q;
  logic                we_q;
  logic [NB_CORES-1:0] data_q;

  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_q != CntW'(CntMax)) begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck_i or posedge tlr_i) begin
    if (tlr_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hdr_q      <= '0;
      wdat_q     <= '0;
      out_sr_q   <= '0;
      err_q      <= 1'b0;
      rd_armed_q <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (capture_dr_i) begin
        state_q <= StHdr;
        cnt_q   <= '0;
        // Cleared so an empty frame never looks like a top-level select.
        hdr_q   <= '0;
        if (module_select_i && rd_armed_q) begin
          out_sr_q   <= {ctrl_reg_i, err_q};
          err_q      <= 1'b0;
          rd_armed_q <= 1'b0;
        end else begin
          out_sr_q <= '0;
        end
      end else if (shift_dr_i) begin
        if (module_select_i) begin
          for (int unsigned i = 0; i < HDR_W; i++) begin
            if (cnt_q == CntW'(i)) hdr_q[i] <= tdi_i;
          end
          for (int unsigned i = 0; i < NB_CORES; i++) begin
            if (cnt_q == CntW'(HDR_W + i)) wdat_q[i] <= tdi_i;
          end
          cnt_q    <= cnt_nxt;
          out_sr_q <= {1'b0, out_sr_q[NB_CORES:1]};
          if (cnt_nxt < CntW'(HDR_W)) begin
            state_q <= StHdr;
          end else if (cnt_nxt < CntW'(CntMax)) begin
            state_q <= StWdata;
          end else begin
            state_q <= StFull;
          end
        end
      end else if (update_dr_i) begin
        state_q <= StIdle;
        if (module_select_i && !hdr_q[0]) begin
          if (cnt_q < CntW'(HDR_W)) begin
            err_q <= 1'b1;
          end else begin
            case (hdr_q[4:1])
              OpIregWr: begin
                if (state_q == StFull) begin
                  we_q   <= 1'b1;
                  data_q <= wdat_q;
                end else begin
                  err_q <= 1'b1;
                end
              end
              OpIregSel: rd_armed_q <= 1'b1;
              OpNop:     ;
              default:   err_q <= 1'b1;
            endcase
          end
        end
      end
    end
  end

  assign tdo_o  = out_sr_q[0];
  assign we_o   = we_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_adbg_or1k_ctrl_shifter.sv
// Directed and randomized checks of the or1k control shifter against a frame-level model.
module tb_adbg_or1k_ctrl_shifter;

  localparam int unsigned NB = 4;

  logic          tck = 1'b0;
  logic          tlr;
  logic          module_select;
  logic          capture_dr;
  logic          shift_dr;
  logic          update_dr;
  logic          tdi;
  logic          tdo;
  logic [NB-1:0] ctrl_reg;
  logic          we;
  logic [NB-1:0] data;

  int unsigned passes = 0;
  int unsigned total  = 0;

  // Reference model: received frame bits, pending readback bits, sticky flags.
  bit            frame[$];
  bit            outq[$];
  bit            m_err;
  bit            m_rd;
  bit            m_we;
  logic [NB-1:0] m_data;

  adbg_or1k_ctrl_shifter #(.NB_CORES(NB)) dut (
    .tck_i          (tck),
    .tlr_i          (tlr),
    .module_select_i(module_select),
    .capture_dr_i   (capture_dr),
    .shift_dr_i     (shift_dr),
    .update_dr_i    (update_dr),
    .tdi_i          (tdi),
    .tdo_o          (tdo),
    .ctrl_reg_i     (ctrl_reg),
    .we_o           (we),
    .data_o         (data)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    outq.delete();
    m_err  = 1'b0;
    m_rd   = 1'b0;
    m_we   = 1'b0;
    m_data = '0;
  endtask

  task automatic model_update();
    int unsigned   n;
    logic [3:0]    op;
    logic [NB-1:0] d;
    n = frame.size();
    if (n > 0 && frame[0]) return;
    if (n < 5) begin
      m_err = 1'b1;
      return;
    end
    op = {frame[4], frame[3], frame[2], frame[1]};
    if (op == 4'h9) begin
      if (n == 5 + NB) begin
        for (int i = 0; i < NB; i++) d[i] = frame[5 + i];
        m_we   = 1'b1;
        m_data = d;
      end else begin
        m_err = 1'b1;
      end
    end else if (op == 4'hD) begin
      m_rd = 1'b1;
    end else if (op != 4'h0) begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_step(input bit cap, input bit sh, input bit upd, input bit sel,
                            input bit b);
    m_we = 1'b0;
    if (cap) begin
      frame.delete();
      outq.delete();
      if (sel && m_rd) begin
        outq.push_back(m_err);
        for (int i = 0; i < NB; i++) outq.push_back(ctrl_reg[i]);
        m_err = 1'b0;
        m_rd  = 1'b0;
      end
    end else if (sh) begin
      if (sel) begin
        if (frame.size() < 5 + NB) frame.push_back(b);
        if (outq.size() > 0) void'(outq.pop_front());
      end
    end else if (upd) begin
      if (sel) model_update();
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " we"}, 32'(we), 32'(m_we));
    chk({tag, " data"}, 32'(data), 32'(m_data));
    chk({tag, " tdo"}, 32'(tdo), (outq.size() > 0) ? 32'(outq[0]) : 32'd0);
  endtask

  task automatic cyc(input bit cap, input bit sh, input bit upd, input bit sel, input bit b,
                     input string tag);
    capture_dr    = cap;
    shift_dr      = sh;
    update_dr     = upd;
    module_select = sel;
    tdi           = b;
    @(posedge tck);
    model_step(cap, sh, upd, sel, b);
    #1;
    check_outs(tag);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
  endtask

  // Capture, shift nbits of {d, op, top} LSB first, then update (no trailing idle).
  task automatic send_frame(input bit top, input logic [3:0] op, input logic [NB-1:0] d,
                            input int nbits, input bit sel_sh, input bit sel_upd);
    logic [4+NB:0] v;
    v = {d, op, top};
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "cap");
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b0, 1'b1, 1'b0, sel_sh, (i < 5 + NB) ? v[i] : 1'($urandom), "sh");
    end
    cyc(1'b0, 1'b0, 1'b1, sel_upd, 1'b0, "upd");
  endtask

  // Arm a read, then capture; tdo then shows the first (error) bit.
  task automatic arm_and_capture(input logic [NB-1:0] ctrl);
    send_frame(1'b0, 4'hD, '0, 5, 1'b1, 1'b1);
    idle();
    ctrl_reg = ctrl;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rdcap");
  endtask

  initial begin
    logic [3:0] ops[4];
    bit         top;
    int         n;
    tlr           = 1'b1;
    module_select = 1'b0;
    capture_dr    = 1'b0;
    shift_dr      = 1'b0;
    update_dr     = 1'b0;
    tdi           = 1'b0;
    ctrl_reg      = '0;
    model_reset();
    #12;
    chk("reset we", 32'(we), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset tdo", 32'(tdo), 32'd0);
    @(negedge tck);
    tlr = 1'b0;

    // Write 4'b1010: strobe exactly one cycle after update.
    send_frame(1'b0, 4'h9, 4'b1010, 9, 1'b1, 1'b1);
    chk("wr we high", 32'(we), 32'd1);
    chk("wr data", 32'(data), 32'hA);
    idle();
    chk("wr we low", 32'(we), 32'd0);
    chk("wr data hold", 32'(data), 32'hA);

    // Read: ctrl 4'b0110 gives tdo 0,0,1,1,0.
    arm_and_capture(4'b0110);
    chk("rd b0", 32'(tdo), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rdsh");
    chk("rd b1", 32'(tdo), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rdsh");
    chk("rd b2", 32'(tdo), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rdsh");
    chk("rd b3", 32'(tdo), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rdsh");
    chk("rd b4", 32'(tdo), 32'd0);
    idle();

    // Short write: no strobe, error reported once then cleared.
    send_frame(1'b0, 4'h9, 4'b0101, 7, 1'b1, 1'b1);
    chk("short we", 32'(we), 32'd0);
    chk("short data", 32'(data), 32'hA);
    idle();
    arm_and_capture(4'b0000);
    chk("short err1", 32'(tdo), 32'd1);
    idle();
    arm_and_capture(4'b0000);
    chk("short err2", 32'(tdo), 32'd0);
    idle();

    // Top-select set: frame ignored, no error.
    send_frame(1'b1, 4'h9, 4'b0011, 9, 1'b1, 1'b1);
    chk("topsel we", 32'(we), 32'd0);
    idle();
    arm_and_capture(4'b0000);
    chk("topsel err", 32'(tdo), 32'd0);
    idle();

    // Reset mid-frame after 6 bits, then a fresh write of 4'b0101.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "cap");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, (i == 1 || i == 4), "sh");
    tlr = 1'b1;
    #1;
    model_reset();
    chk("rst we", 32'(we), 32'd0);
    chk("rst data", 32'(data), 32'd0);
    chk("rst tdo", 32'(tdo), 32'd0);
    #2;
    tlr = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst upd");
    chk("rst no we", 32'(we), 32'd0);
    send_frame(1'b0, 4'h9, 4'b0101, 9, 1'b1, 1'b1);
    chk("post rst we", 32'(we), 32'd1);
    chk("post rst data", 32'(data), 32'h5);
    idle();

    // Deselected shifting: counter stays at 0, so a selected update flags an error.
    send_frame(1'b0, 4'h9, 4'b1111, 9, 1'b0, 1'b1);
    chk("desel we", 32'(we), 32'd0);
    idle();
    arm_and_capture(4'b0000);
    chk("desel err", 32'(tdo), 32'd1);
    idle();
    send_frame(1'b0, 4'h9, 4'b1111, 9, 1'b0, 1'b0);
    idle();
    arm_and_capture(4'b0000);
    chk("desel noerr", 32'(tdo), 32'd0);
    idle();

    // Randomized frames and readbacks against the model.
    ops[0] = 4'h0;
    ops[1] = 4'h9;
    ops[2] = 4'hD;
    for (int f = 0; f < 150; f++) begin
      ops[3] = 4'($urandom);
      top    = ($urandom_range(0, 7) == 0);
      n      = $urandom_range(0, 11);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rcap");
      for (int i = 0; i < n; i++) begin
        logic [4+NB:0] v;
        v = {4'($urandom), ops[$urandom_range(0, 3)], top};
        cyc(1'b0, 1'b1, 1'b0, ($urandom_range(0, 5) != 0),
            (i < 5 + NB) ? v[i] : 1'($urandom), "rsh");
      end
      cyc(1'b0, 1'b0, 1'b1, ($urandom_range(0, 7) != 0), 1'b0, "rupd");
      idle();
      if ($urandom_range(0, 1) == 1) begin
        ctrl_reg = 4'($urandom);
        cyc(1'b1, 1'b0, 1'b0, ($urandom_range(0, 5) != 0), 1'b0, "rrdcap");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rrdsh");
        idle();
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
